// File: rtl/intt_sdf_stage.sv
// -----------------------------------------------------------------------------
// intt_sdf_stage
//
// One radix-2 inverse-NTT stage in single-path delay-feedback form. The first
// HALF samples of each frame are parked in a feedback FIFO (FILL phase). Each of
// the next HALF samples is multiplied by its inverse twiddle and butterflied
// against the FIFO head (BFLY phase). The sum leaves immediately. The
// difference is pushed back into the FIFO and drains during the following FILL
// phase, overlapping the next frame's fill.
//
// Ports
//   clk         single clock, all state on the rising edge
//   rst         synchronous, active-low reset
//   in_valid    in_data carries a sample this cycle (no backpressure)
//   in_data     input residue, < MODULUS
//   write_en    inverse-twiddle RAM write strobe
//   write_addr  inverse-twiddle RAM write address
//   write_data  inverse-twiddle value, < MODULUS
//   out_valid   out_data carries a result this cycle (registered)
//   out_data    output residue (registered, holds when out_valid=0)
//   busy        a frame is partially accepted or difference results are queued
// -----------------------------------------------------------------------------
module intt_sdf_stage #(
  parameter int W        = 32,
  parameter int MODULUS  = 7681,
  parameter int HALF     = 4,
  parameter int TW_DEPTH = HALF,
  localparam int AW      = (TW_DEPTH > 1) ? $clog2(TW_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          write_en,
  input  logic [AW-1:0] write_addr,
  input  logic [W-1:0]  write_data,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          busy
);

  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;  // FIFO pointer / k width
  localparam int CW = $clog2(HALF + 1);               // pend counter width

  localparam logic [PW-1:0]  LAST   = PW'(HALF - 1);
  localparam logic [W-1:0]   Q      = W'(MODULUS);
  localparam logic [W:0]     Q_EXT  = (W + 1)'(MODULUS);
  localparam logic [2*W-1:0] Q_WIDE = (2 * W)'(MODULUS);

  typedef enum logic {
    FILL = 1'b0,
    BFLY = 1'b1
  } phase_e;

  // State
  phase_e        phase, phase_nxt;
  logic [PW-1:0] k, k_nxt;
  logic [CW-1:0] pend, pend_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic          out_valid_nxt;
  logic [W-1:0]  out_data_nxt;

  // NOTE: the FIFO and twiddle storage carry no reset; the pointers and pend
  // counter define which entries are meaningful, and twiddles must survive rst.
  logic [W-1:0] fifo_mem [HALF];
  logic [W-1:0] tw_mem   [TW_DEPTH];

  // Datapath
  logic           push, pop;
  logic [W-1:0]   push_data;
  logic [W-1:0]   head, tw, t;
  logic [2*W-1:0] prod;
  logic [W:0]     sum;
  logic [W-1:0]   sum_mod, diff_mod;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Modular butterfly. The product needs the full 2W bits before reduction;
  // sum and difference fit in W+1 bits because both operands are < q.
  always_comb begin
    head     = fifo_mem[rd_ptr];
    tw       = tw_mem[AW'(k)];
    prod     = {{W{1'b0}}, in_data} * {{W{1'b0}}, tw};
    t        = W'(prod % Q_WIDE);
    sum      = {1'b0, head} + {1'b0, t};
    sum_mod  = (sum >= Q_EXT) ? W'(sum - Q_EXT) : W'(sum);
    diff_mod = (head >= t) ? (head - t) : W'({1'b0, head} + Q_EXT - {1'b0, t});
  end

  // Next-state / output decode.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    phase_nxt     = phase;
    k_nxt         = k;
    pend_nxt      = pend;
    push          = 1'b0;
    pop           = 1'b0;
    push_data     = in_data;
    out_valid_nxt = 1'b0;
    out_data_nxt  = out_data;

    unique case (phase)
      FILL: begin
        // Drain queued differences independently of the input.
        if (pend != '0) begin
          pop           = 1'b1;
          out_valid_nxt = 1'b1;
          out_data_nxt  = head;
          pend_nxt      = pend - CW'(1);
        end
        if (in_valid) begin
          push = 1'b1;
          k_nxt = wrap_inc(k);
          if (k == LAST) phase_nxt = BFLY;
        end
      end
      BFLY: begin
        if (in_valid) begin
          pop           = 1'b1;
          push          = 1'b1;
          push_data     = diff_mod;
          out_valid_nxt = 1'b1;
          out_data_nxt  = sum_mod;
          pend_nxt      = pend + CW'(1);
          k_nxt         = wrap_inc(k);
          if (k == LAST) phase_nxt = FILL;
        end
      end
      default: ;
    endcase

    rd_ptr_nxt = pop  ? wrap_inc(rd_ptr) : rd_ptr;
    wr_ptr_nxt = push ? wrap_inc(wr_ptr) : wr_ptr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase     <= FILL;
      k         <= '0;
      pend      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      phase     <= phase_nxt;
      k         <= k_nxt;
      pend      <= pend_nxt;
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  // Same-cycle read of a written address sees the old word.
  always_ff @(posedge clk) begin
    if (write_en) tw_mem[write_addr] <= write_data;
  end

  assign busy = (phase == BFLY) || (k != '0) || (pend != '0);

  // During FILL the queued differences plus parked samples never exceed the
  // FIFO depth; during BFLY every accept adds exactly one difference, so pend
  // tracks k (and is therefore zero on entry).
  fill_occupancy : assert property (@(posedge clk) disable iff (!rst)
    (phase == FILL) |-> (int'(pend) + int'(k) <= HALF));
  bfly_balance : assert property (@(posedge clk) disable iff (!rst)
    (phase == BFLY) |-> (int'(pend) == int'(k)));

endmodule

// File: tb/tb_intt_sdf_stage.sv
module tb_intt_sdf_stage;

  localparam int W  = 32;
  localparam int Q  = 7681;
  localparam int H  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          write_en = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [W-1:0]  write_data = '0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          busy;

  intt_sdf_stage #(.W(W), .MODULUS(Q), .HALF(H), .TW_DEPTH(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: frame-level inverse butterfly, outputs scheduled by cycle.
  longint tw_m [H];
  longint fx   [2*H];
  longint bq   [H];
  longint fr   [2*H];
  int     cnt    = 0;      // samples accepted in the current frame
  int     last_b = -1;     // cycle after which no difference remains queued
  longint exp_out [int];   // expected out_data keyed by edge number
  longint last_out = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, want %0d", tag, cyc, got, want);
    end
  endtask

  task automatic model_edge();
    if (write_en) tw_m[write_addr] = longint'(write_data);
    if (!rst) begin
      exp_out.delete();
      cnt      = 0;
      last_b   = -1;
      last_out = 0;
    end else if (in_valid) begin
      fx[cnt] = longint'(in_data);
      if (cnt >= H) begin
        int     j = cnt - H;
        longint t = (fx[cnt] * tw_m[j]) % Q;
        exp_out[cyc] = (fx[j] + t) % Q;
        bq[j]        = (fx[j] + Q - t) % Q;
      end
      if (cnt == 2*H - 1) begin
        for (int j = 0; j < H; j++) exp_out[cyc + 1 + j] = bq[j];
        last_b = cyc + H;
        cnt    = 0;
      end else begin
        cnt++;
      end
    end
  endtask

  task automatic cycle(input bit v, input longint d);
    bit ev;
    in_valid = v;
    in_data  = W'(d);
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    ev = exp_out.exists(cyc);
    check("out_valid", {63'd0, out_valid}, {63'd0, ev});
    if (ev) begin
      check("out_data", {32'd0, out_data}, exp_out[cyc]);
      last_out = exp_out[cyc];
      exp_out.delete(cyc);
    end else begin
      check("out_hold", {32'd0, out_data}, last_out);
    end
    check("busy", {63'd0, busy}, {63'd0, (cnt != 0) || (cyc < last_b)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, longint'($urandom_range(0, Q - 1)));
  endtask

  task automatic load_tw(input int a, input longint v);
    write_en   = 1'b1;
    write_addr = AW'(a);
    write_data = W'(v);
    cycle(1'b0, 0);
    write_en   = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < 2*H; i++) begin
      if (gaps && i > 0) cycle(1'b0, longint'($urandom_range(0, Q - 1)));
      cycle(1'b1, fr[i]);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 2*H; i++) fr[i] = longint'($urandom_range(0, Q - 1));
  endtask

  initial begin
    // Reset held two cycles with in_valid asserted: nothing may be accepted.
    rst = 1'b0;
    cycle(1'b1, 11);
    cycle(1'b1, 22);
    rst = 1'b1;
    idle(2);

    // All-ones twiddles, frame 1..8.
    for (int i = 0; i < H; i++) load_tw(i, 1);
    for (int i = 0; i < 2*H; i++) fr[i] = i + 1;
    send_frame(1'b0);
    idle(H + 2);

    // Twiddles 1..4, frame of four zeros then four ones.
    for (int i = 0; i < H; i++) load_tw(i, i + 1);
    for (int i = 0; i < 2*H; i++) fr[i] = (i < H) ? 0 : 1;
    send_frame(1'b0);
    idle(H + 2);

    // Modular wrap on the sum and on the difference (tw[0] is 1).
    rand_frame();
    fr[0] = Q - 1;
    fr[H] = Q - 1;
    send_frame(1'b0);
    rand_frame();
    fr[0] = 0;
    fr[H] = 1;
    send_frame(1'b0);
    idle(H + 2);

    // Random twiddles; back-to-back frames, then a frame with single gaps.
    for (int i = 0; i < H; i++) load_tw(i, longint'($urandom_range(0, Q - 1)));
    rand_frame(); send_frame(1'b0);
    rand_frame(); send_frame(1'b0);
    rand_frame(); send_frame(1'b1);
    idle(H + 2);

    // Reset in the middle of BFLY, then a clean frame with the same twiddles.
    rand_frame();
    for (int i = 0; i < H + 2; i++) cycle(1'b1, fr[i]);
    rst = 1'b0;
    cycle(1'b1, 5);
    rst = 1'b1;
    rand_frame(); send_frame(1'b0);
    idle(H + 2);

    // Random valid pattern over many frames with fresh twiddles.
    for (int i = 0; i < H; i++) load_tw(i, longint'($urandom_range(0, Q - 1)));
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 9) < 7, longint'($urandom_range(0, Q - 1)));
    // Finish the partial frame, then drain.
    while (cnt != 0) cycle(1'b1, longint'($urandom_range(0, Q - 1)));
    idle(2*H + 2);

    check("drained", 64'(exp_out.num()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intt_sdf_stage.md
# intt_sdf_stage

Single radix-2 inverse-NTT stage in single-path delay-feedback (SDF) form. Each stage consumes one residue per cycle, multiplies the upper-half sample by an inverse twiddle (mod MODULUS), then butterflies it against the lower-half sample held in a feedback FIFO. Stages chain back-to-back after the forward-NTT pipeline to rebuild coefficient order. The twiddle RAM is loaded through the same write port style as the forward stage.

## Interface
- W, 32, data width of every residue port
- MODULUS, 7681, prime modulus q; all inputs must be < q
- HALF, 4, butterfly span; feedback FIFO depth; frame length is 2·HALF (power of two, ≥1)
- TW_DEPTH, HALF, inverse-twiddle RAM entries

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  in_data is a sample this cycle; no backpressure
- in_data  in  W  input residue
- write_en  in  1  twiddle RAM write strobe
- write_addr  in  $clog2(TW_DEPTH)  twiddle RAM write address
- write_data  in  W  inverse twiddle value (< q)
- out_valid  out  1  out_data valid this cycle (registered)
- out_data  out  W  output residue (registered)
- busy  out  1  FIFO non-empty or mid-frame

## Operation
- Phases: FILL, BFLY. Counter k (0..HALF-1) counts accepted samples in current phase; phase toggles when k wraps after HALF accepts.
- Feedback FIFO (depth HALF, circular, read/write pointers) plus pend counter (0..HALF) = number of b results queued at FIFO head.
- FILL, per cycle: if pend>0 pop head, emit it (out_valid=1), pend−1. Independently, if in_valid push in_data, k+1. Push and pop in same cycle allowed.
- BFLY, on in_valid: x=in_data, tw=twram[k], t=(x·tw) mod q (2W-bit product), h=FIFO head (pop). Emit a=(h+t) mod q. Push b=(h−t) mod q, pend+1, k+1. No in_valid → no pop, no push, out_valid=0.
- Arithmetic: sum s=h+t, subtract q if s≥q. Diff: h≥t ? h−t : h+q−t. Results always in [0,q).
- pend is guaranteed 0 at BFLY entry (FILL lasts ≥HALF cycles, drains one per cycle); occupancy never exceeds HALF. Implementation asserts this in simulation.
- After final frame the HALF b values drain in FILL automatically, no input required.
- Twiddle RAM: write on write_en at clock edge; read combinational. Same-cycle read/write of one address returns old value. Not cleared by reset.
- busy = (phase==BFLY) | (k≠0) | (pend≠0).

## Timing
- Reset (rst=0 at edge): out_valid=0, out_data=0, phase=FILL, k=0, pend=0, FIFO pointers 0. Twiddle contents kept. Reset mid-frame discards all in-flight samples; first sample after rst=1 is frame sample 0.
- Latency: a-output one cycle after the accepting BFLY edge; b-outputs begin the cycle after the last BFLY accept (one per cycle, HALF cycles), regardless of in_valid.
- Output order per frame: a0..a(HALF−1), then b0..b(HALF−1). Back-to-back frames: continuous out_valid, b's of frame f overlap FILL of frame f+1.
- Gaps in in_valid: freeze k and phase; FILL-phase drain continues.
- out_data holds last value when out_valid=0.

## Test plan
- Reset: rst=0 two cycles with in_valid=1 → out_valid=0, out_data=0, busy=0 after release.
- tw all 1, frame 1..8 contiguous → a=6,8,10,12 on cycles 5–8 after first accept+1; b=7677×4 on next four cycles with in_valid=0.
- tw={1,2,3,4}, frame 0,0,0,0,1,1,1,1 → a=1,2,3,4; b=7680,7679,7678,7677.
- Wrap: tw[0]=1, x0=7680, x4=7680 → a0=7679, b0=0; x0=0, x4=1 → b0=7680.
- Two frames back-to-back, then one with single-cycle in_valid gaps → output stream identical in order/values to gap-free golden model, no drops, pend never >4.
- rst=0 during BFLY of frame 0, then clean frame → only clean frame results appear; twiddles unchanged.
